bus_fabric: RTL and testbench
=============================

Name: bus_fabric

Overview:
- Parametrised bus decoder/multiplexer for the RISC5 word-addressed master bus.
- Successor to hard-coded per-slave strobe/data/ack decoding in the top level: NUM_SLV slaves, each with a configurable base/mask window, fixed priority.
- Adds an unmapped-access responder, a per-access ack timeout watchdog and an error capture register with interrupt.
- Sits between cpu and all memory/I/O slaves.

Parameters:
- NUM_SLV, 8, number of slave ports (1..16).
- AW, 22, master word-address width (byte address bits [AW+1:2]).
- SLV_BASE, {NUM_SLV{AW'h0}}, flattened NUM_SLV*AW base word addresses; slave i at bits [i*AW +: AW].
- SLV_MASK, {NUM_SLV{AW'h0}}, flattened NUM_SLV*AW compare masks; 1 = bit compared.
- TMO_CYC, 255, cycles allowed for slave ack; 0 disables timeout.
- ERR_DATA, 32'h00000000, read data returned on forced (error) ack.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_stb  in  1  master strobe
- m_we  in  1  master write enable
- m_addr  in  AW  master word address
- m_rdata  out  32  read data to master
- m_ack  out  1  acknowledge to master
- s_stb  out  NUM_SLV  per-slave strobe
- s_rdata  in  NUM_SLV*32  flattened slave read data, slave i at [i*32 +: 32]
- s_ack  in  NUM_SLV  per-slave acknowledge
- err_clr  in  1  single-cycle pulse: clear error capture
- err_valid  out  1  error captured
- err_ovf  out  1  further error while err_valid set
- err_cause  out  1  0 = unmapped, 1 = timeout
- err_we  out  1  m_we of captured access
- err_addr  out  AW  m_addr of captured access
- err_irq  out  1  equals err_valid

Behaviour:
- Reset (rst_n low, async): cnt=0, err_valid=0, err_ovf=0, err_cause=0, err_we=0, err_addr=0. s_stb, m_ack and m_rdata are combinational and are 0 while m_stb=0.
- Decode, combinational: hit_i = ((m_addr ^ SLV_BASE_i) & SLV_MASK_i) == 0. sel = lowest i with hit_i. s_stb[sel] = m_stb; all other s_stb bits are 0. Overlapping windows resolve to the lower index.
- Mapped data path: m_rdata = s_rdata[sel], m_ack = s_ack[sel] | force. s_ack of unselected slaves is ignored.
- Wait counter: cnt <= (!m_stb || m_ack) ? 0 : cnt+1. Width is clog2(TMO_CYC+2). cnt saturates; it never wraps.
- Unmapped access (no hit_i):
  - No s_stb is asserted.
  - force = m_stb & (cnt==1), so the ack arrives exactly 1 cycle after strobe assertion.
  - m_rdata = ERR_DATA; writes are discarded.
- Timeout (mapped access, TMO_CYC>0):
  - force = m_stb & (cnt==TMO_CYC) & !s_ack[sel].
  - The ack arrives TMO_CYC cycles after strobe assertion, with m_rdata = ERR_DATA.
  - A slave ack in the same cycle wins: slave data is returned and no error is recorded.
- m_ack is asserted for exactly one cycle per access. If m_stb stays high after an ack, the next cycle starts a new access with cnt=0.
- Error capture, on the clock edge ending a forced-ack cycle:
  - err_valid=0: latch cause, m_we, m_addr; set err_valid.
  - err_valid=1: keep the first capture; set err_ovf.
- err_clr:
  - Clears err_valid and err_ovf.
  - If err_clr and a new error land on the same edge, the new error is captured (err_valid=1) and err_ovf=0.
- The master must hold m_addr and m_we stable while m_stb=1. If m_stb drops before ack (abort), cnt returns to 0 and no error is recorded.
- Reset mid-access: cnt and error state clear immediately. The outputs follow the combinational rules once rst_n is released.

Test Plan:
- Reset: default map (4 slaves, e.g. PROM 0xFFE000 mask 0x3FFC00, RAM 0x000000 mask 0x200000) -> after rst_n release all err_* = 0 and s_stb = 0.
- Mapped read: slave 1 acks 3 cycles after strobe with 0x12345678 -> s_stb=4'b0010; m_ack is a 1-cycle pulse in the same cycle as s_ack; m_rdata=0x12345678; err_valid=0.
- Overlap: address hits slave 0 and slave 2 -> only s_stb[0]=1; slave 2 ack ignored.
- Unmapped write to word 0x3FFFF0 -> no s_stb; m_ack 1 cycle after strobe; err_valid=1, err_cause=0, err_we=1, err_addr=0x3FFFF0.
- Timeout, TMO_CYC=4: silent slave 3 -> m_ack at cycle 4, m_rdata=ERR_DATA, err_cause=1. Repeat access -> err_ovf=1 and err_addr unchanged. Slave ack exactly at cycle 4 -> no error.
- err_clr pulsed on the same edge as a new unmapped error -> err_valid=1, err_ovf=0, err_addr = new address. Async rst_n pulse mid-wait -> cnt=0, err_valid=0 without a clock edge.

Source files
------------

// File: rtl/bus_fabric_if.sv
// Master-side bus bundle for bus_fabric: cpu strobe/address/data plus the per-slave
// strobe/ack/read-data fan-out. "slave" is the fabric's view; "master" drives the fabric.
interface bus_fabric_if #(
    parameter int NUM_SLV = 8,
    parameter int AW      = 22
);
    logic                    m_stb;
    logic                    m_we;
    logic [AW-1:0]           m_addr;
    logic [31:0]             m_rdata;
    logic                    m_ack;
    logic [NUM_SLV-1:0]      s_stb;
    logic [NUM_SLV*32-1:0]   s_rdata;
    logic [NUM_SLV-1:0]      s_ack;

    modport master (
        output m_stb, m_we, m_addr, s_rdata, s_ack,
        input  m_rdata, m_ack, s_stb
    );

    modport slave (
        input  m_stb, m_we, m_addr, s_rdata, s_ack,
        output m_rdata, m_ack, s_stb
    );
endinterface

// File: rtl/bus_fabric.sv
// Word-address decoder/mux for the RISC5 master bus: fixed-priority base/mask windows,
// unmapped-access responder, ack timeout watchdog and first-error capture with interrupt.
module bus_fabric #(
    parameter int                  NUM_SLV  = 8,
    parameter int                  AW       = 22,
    parameter logic [NUM_SLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*AW-1:0] SLV_MASK = '0,
    parameter int                  TMO_CYC  = 255,
    parameter logic [31:0]         ERR_DATA = 32'h00000000
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_fabric_if.slave   bus,
    input  logic          err_clr,
    output logic          err_valid,
    output logic          err_ovf,
    output logic          err_cause,
    output logic          err_we,
    output logic [AW-1:0] err_addr,
    output logic          err_irq
);

    localparam int CW = $clog2(TMO_CYC + 2);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0]      cnt;
    logic               mapped;
    logic [NUM_SLV-1:0] sel_oh;
    logic               sel_ack;
    logic [31:0]        sel_rdata;
    logic               tmo_hit;
    logic               force_ack;

    // Walk from the top index down so the lowest matching window is the one left standing.
    always_comb begin
        mapped    = 1'b0;
        sel_oh    = '0;
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (((bus.m_addr ^ SLV_BASE[i*AW +: AW]) & SLV_MASK[i*AW +: AW]) == '0) begin
                mapped    = 1'b1;
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_ack   = bus.s_ack[i];
                sel_rdata = bus.s_rdata[i*32 +: 32];
            end
        end
    end

    assign tmo_hit   = (TMO_CYC != 0) && (cnt == CW'(TMO_CYC));
    assign force_ack = bus.m_stb & (mapped ? (tmo_hit & ~sel_ack) : (cnt == CW'(1)));

    assign bus.s_stb   = bus.m_stb ? sel_oh : '0;
    assign bus.m_ack   = (bus.m_stb & mapped & sel_ack) | force_ack;
    assign bus.m_rdata = !bus.m_stb                ? 32'h0 :
                         (mapped && !force_ack)    ? sel_rdata : ERR_DATA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!bus.m_stb || bus.m_ack) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A clear landing with a new error still records that error as the fresh first capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_ovf   <= 1'b0;
            err_cause <= 1'b0;
            err_we    <= 1'b0;
            err_addr  <= '0;
        end else if (force_ack) begin
            if (!err_valid || err_clr) begin
                err_valid <= 1'b1;
                err_ovf   <= 1'b0;
                err_cause <= mapped;
                err_we    <= bus.m_we;
                err_addr  <= bus.m_addr;
            end else begin
                err_ovf   <= 1'b1;
            end
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_ovf   <= 1'b0;
        end
    end

    assign err_irq = err_valid;

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboarded bench for bus_fabric: four-window map, mapped/overlap/unmapped/timeout
// accesses, error capture/overflow/clear collision and asynchronous reset mid-wait.
module tb_bus_fabric;
    localparam int NUM_SLV = 4;
    localparam int AW      = 22;
    localparam int TMO_CYC = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
    // Slave 0 RAM (low half), 1 PROM, 2 overlaps RAM, 3 I/O page.
    localparam logic [NUM_SLV*AW-1:0] SLV_BASE =
        {22'h3FC000, 22'h100000, 22'h3FF800, 22'h000000};
    localparam logic [NUM_SLV*AW-1:0] SLV_MASK =
        {22'h3FFF00, 22'h3F0000, 22'h3FFC00, 22'h200000};

    typedef struct {
        int          lat;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          err_clr;
    logic          err_valid, err_ovf, err_cause, err_we, err_irq;
    logic [AW-1:0] err_addr;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   dly[NUM_SLV];
    exp_t sb[$];

    bus_fabric_if #(.NUM_SLV(NUM_SLV), .AW(AW)) bif ();

    bus_fabric #(
        .NUM_SLV (NUM_SLV),
        .AW      (AW),
        .SLV_BASE(SLV_BASE),
        .SLV_MASK(SLV_MASK),
        .TMO_CYC (TMO_CYC),
        .ERR_DATA(ERR_DATA)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bif.slave),
        .err_clr  (err_clr),
        .err_valid(err_valid),
        .err_ovf  (err_ovf),
        .err_cause(err_cause),
        .err_we   (err_we),
        .err_addr (err_addr),
        .err_irq  (err_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic pulse_clr();
        @(posedge clk) #1;
        err_clr = 1'b1;
        @(posedge clk) #1;
        err_clr = 1'b0;
    endtask

    // One access: expected latency/data go to the scoreboard at strobe, checked at m_ack.
    task automatic do_access(input logic [AW-1:0] addr, input logic we,
                             input logic [NUM_SLV-1:0] exp_stb, input int exp_lat,
                             input logic [31:0] exp_data, input bit clr_on_ack);
        exp_t e;
        int   k;
        bit   acked;
        e.lat  = exp_lat;
        e.data = exp_data;
        sb.push_back(e);
        @(posedge clk) #1;
        bif.m_addr = addr;
        bif.m_we   = we;
        bif.m_stb  = 1'b1;
        k     = 0;
        acked = 1'b0;
        while (!acked && k < 20) begin
            for (int i = 0; i < NUM_SLV; i++) bif.s_ack[i] = (k == dly[i]);
            @(negedge clk);
            if (k == 0) chk("s_stb", 32'(bif.s_stb), 32'(exp_stb));
            if (bif.m_ack) begin
                acked = 1'b1;
                e = sb.pop_front();
                chk("ack_latency", k, e.lat);
                chk("m_rdata", bif.m_rdata, e.data);
                if (clr_on_ack) err_clr = 1'b1;
            end
            @(posedge clk) #1;
            err_clr = 1'b0;
            k++;
        end
        if (!acked) begin
            chk("ack_bound", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        bif.m_stb = 1'b0;
        bif.s_ack = '0;
        @(negedge clk);
        chk("ack_pulse", 32'(bif.m_ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_t e;
        int   k;
        bit   acked;
        rst_n       = 1'b0;
        err_clr     = 1'b0;
        bif.m_stb   = 1'b0;
        bif.m_we    = 1'b0;
        bif.m_addr  = '0;
        bif.s_ack   = '0;
        bif.s_rdata = {32'hCAFEF00D, 32'hBBBB2222, 32'h12345678, 32'hA0A0A0A0};
        dly         = '{-1, -1, -1, -1};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_ovf",   32'(err_ovf),   32'd0);
        chk("rst_err_cause", 32'(err_cause), 32'd0);
        chk("rst_err_we",    32'(err_we),    32'd0);
        chk("rst_err_addr",  32'(err_addr),  32'd0);
        chk("rst_err_irq",   32'(err_irq),   32'd0);
        chk("rst_s_stb",     32'(bif.s_stb), 32'd0);
        chk("rst_m_ack",     32'(bif.m_ack), 32'd0);
        chk("rst_m_rdata",   bif.m_rdata,    32'd0);

        // Mapped PROM read, slave acks on cycle 3
        dly = '{-1, 3, -1, -1};
        do_access(22'h3FF900, 1'b0, 4'b0010, 3, 32'h12345678, 1'b0);
        chk("map_err_valid", 32'(err_valid), 32'd0);

        // Overlap: slave 0 wins, the earlier slave 2 ack must be ignored
        dly = '{2, -1, 1, -1};
        do_access(22'h100010, 1'b0, 4'b0001, 2, 32'hA0A0A0A0, 1'b0);
        chk("ovl_err_valid", 32'(err_valid), 32'd0);

        // Unmapped write
        dly = '{-1, -1, -1, -1};
        do_access(22'h3FFFF0, 1'b1, 4'b0000, 1, ERR_DATA, 1'b0);
        chk("unm_err_valid", 32'(err_valid), 32'd1);
        chk("unm_err_cause", 32'(err_cause), 32'd0);
        chk("unm_err_we",    32'(err_we),    32'd1);
        chk("unm_err_addr",  32'(err_addr),  32'h3FFFF0);
        chk("unm_err_irq",   32'(err_irq),   32'd1);

        pulse_clr();
        chk("clr_err_valid", 32'(err_valid), 32'd0);

        // Timeout on silent I/O slave, then overflow on a repeat
        do_access(22'h3FC010, 1'b0, 4'b1000, TMO_CYC, ERR_DATA, 1'b0);
        chk("tmo_err_valid", 32'(err_valid), 32'd1);
        chk("tmo_err_cause", 32'(err_cause), 32'd1);
        chk("tmo_err_we",    32'(err_we),    32'd0);
        chk("tmo_err_addr",  32'(err_addr),  32'h3FC010);
        chk("tmo_err_ovf",   32'(err_ovf),   32'd0);
        do_access(22'h3FC020, 1'b1, 4'b1000, TMO_CYC, ERR_DATA, 1'b0);
        chk("ovf_err_ovf",   32'(err_ovf),   32'd1);
        chk("ovf_err_addr",  32'(err_addr),  32'h3FC010);
        chk("ovf_err_we",    32'(err_we),    32'd0);

        // Slave ack exactly on the timeout cycle wins
        pulse_clr();
        chk("clr2_err_ovf", 32'(err_ovf), 32'd0);
        dly = '{-1, -1, -1, TMO_CYC};
        do_access(22'h3FC040, 1'b0, 4'b1000, TMO_CYC, 32'hCAFEF00D, 1'b0);
        chk("race_err_valid", 32'(err_valid), 32'd0);

        // Clear colliding with a new error
        dly = '{-1, -1, -1, -1};
        do_access(22'h200000, 1'b0, 4'b0000, 1, ERR_DATA, 1'b0);
        do_access(22'h200004, 1'b0, 4'b0000, 1, ERR_DATA, 1'b0);
        chk("pre_err_ovf",  32'(err_ovf),  32'd1);
        chk("pre_err_addr", 32'(err_addr), 32'h200000);
        do_access(22'h3FFFF0, 1'b1, 4'b0000, 1, ERR_DATA, 1'b1);
        chk("col_err_valid", 32'(err_valid), 32'd1);
        chk("col_err_ovf",   32'(err_ovf),   32'd0);
        chk("col_err_addr",  32'(err_addr),  32'h3FFFF0);
        chk("col_err_we",    32'(err_we),    32'd1);

        // Asynchronous reset two cycles into a timeout wait
        @(posedge clk) #1;
        bif.m_addr = 22'h3FC030;
        bif.m_we   = 1'b0;
        bif.m_stb  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_err_valid", 32'(err_valid),   32'd0);
        chk("arst_err_ovf",   32'(err_ovf),     32'd0);
        chk("arst_err_addr",  32'(err_addr),    32'd0);
        chk("arst_cnt",       32'(u_dut.cnt),   32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        e.lat  = TMO_CYC;
        e.data = ERR_DATA;
        sb.push_back(e);
        k     = 0;
        acked = 1'b0;
        while (!acked && k < 20) begin
            @(negedge clk);
            if (bif.m_ack) begin
                acked = 1'b1;
                e = sb.pop_front();
                chk("arst_latency", k, e.lat);
                chk("arst_rdata", bif.m_rdata, e.data);
            end else begin
                k++;
            end
        end
        if (!acked) begin
            chk("arst_ack_bound", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        @(posedge clk) #1;
        bif.m_stb = 1'b0;
        @(negedge clk);
        chk("arst_err_cause", 32'(err_cause), 32'd1);
        chk("arst_err_addr2", 32'(err_addr),  32'h3FC030);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
